mem_write_checker: RTL and testbench

- Synthesizable, parametrised successor to the single-store pass/fail check used around `top`.
- Sits beside the processor's data-memory port and watches MemWrite/DataAdr/WriteData.
- Matches the observed stores against a programmable list of up to NUM_EXP expected (address, data) pairs, in ordered or unordered mode, with an ignore address and a cycle timeout.
- Reports pass, fail or timeout, with capture of the offending store; used in FPGA bring-up and in gate-level regression.

---
 rtl/mwc_pkg.sv | 28 ++
 rtl/mwc_match_unit.sv | 45 ++++
 rtl/mem_write_checker.sv | 194 +++++++++++++++++++
 tb/tb_mem_write_checker.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mwc_pkg.sv
// Shared types and width helpers for the memory-write checker.
package mwc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_MISMATCH  = 2'd1,
    FC_DUPLICATE = 2'd2,
    FC_TIMEOUT   = 2'd3
  } fail_cause_t;

  // Bits needed to hold the values 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 32'sd1) ? 32'sd1 : $clog2(limit + 32'sd1);
  endfunction

  // Bits needed to index an array of the given number of entries.
  function automatic int idx_width(input int entries);
    return (entries > 32'sd1) ? $clog2(entries) : 32'sd1;
  endfunction

endpackage

// File: rtl/mwc_match_unit.sv
// Compares one observed store against every latched expected entry and
// reports all hits plus the lowest-index hit that is still unmatched.
module mwc_match_unit
  import mwc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  localparam int IW     = idx_width(NUM_EXP)
) (
  input  logic [ADDR_W-1:0]         data_adr,
  input  logic [DATA_W-1:0]         write_data,
  input  logic [NUM_EXP*ADDR_W-1:0] exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data,
  input  logic [NUM_EXP-1:0]        valid,
  input  logic [NUM_EXP-1:0]        matched,
  output logic [NUM_EXP-1:0]        hit_vec,
  output logic                      any_free,
  output logic [IW-1:0]             free_idx
);

  logic [NUM_EXP-1:0] free_vec_s;

  // Per-entry full-width equality, qualified by the active list length
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      hit_vec[i] = valid[i]
                 && (exp_addr[i*ADDR_W +: ADDR_W] == data_adr)
                 && (exp_data[i*DATA_W +: DATA_W] == write_data);
    end
  end

  assign free_vec_s = hit_vec & ~matched;
  assign any_free   = |free_vec_s;

  // Scan downward so the lowest free hit is the one that sticks
  always_comb begin
    free_idx = '0;
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      free_idx = free_vec_s[i] ? IW'(i) : free_idx;
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Watches data-memory stores and matches them against a programmable list of
// expected (address, data) pairs; reports pass, fail or timeout.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int TIMEOUT = 1024,
  localparam int CW     = cnt_width(NUM_EXP)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      ordered,
  input  logic                      ignore_en,
  input  logic [ADDR_W-1:0]         ignore_addr,
  input  logic [CW-1:0]             exp_count,
  input  logic [NUM_EXP*ADDR_W-1:0] exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data,
  input  logic                      mem_write,
  input  logic [ADDR_W-1:0]         data_adr,
  input  logic [DATA_W-1:0]         write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [CW-1:0]             match_cnt,
  output logic [ADDR_W-1:0]         fail_addr,
  output logic [DATA_W-1:0]         fail_data
);

  localparam int TW = cnt_width(TIMEOUT);
  localparam int IW = idx_width(NUM_EXP);

  state_t                    state_r;
  fail_cause_t               cause_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      pass_r;
  logic                      fail_r;
  logic                      ordered_r;
  logic                      ign_en_r;
  logic [ADDR_W-1:0]         ign_addr_r;
  logic [CW-1:0]             exp_cnt_r;
  logic [NUM_EXP*ADDR_W-1:0] exp_addr_r;
  logic [NUM_EXP*DATA_W-1:0] exp_data_r;
  logic [NUM_EXP-1:0]        bitmap_r;
  logic [CW-1:0]             match_cnt_r;
  logic [TW-1:0]             cyc_r;
  logic [ADDR_W-1:0]         fail_addr_r;
  logic [DATA_W-1:0]         fail_data_r;

  logic [NUM_EXP-1:0]        valid_s;
  logic [NUM_EXP-1:0]        hit_s;
  logic                      any_free_s;
  logic [IW-1:0]             free_idx_s;
  logic                      store_s;
  logic                      ord_hit_s;
  logic                      good_s;
  logic                      tmo_s;
  logic [CW-1:0]             next_cnt_s;

  mwc_match_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_EXP (NUM_EXP)
  ) u_match (
    .data_adr   (data_adr),
    .write_data (write_data),
    .exp_addr   (exp_addr_r),
    .exp_data   (exp_data_r),
    .valid      (valid_s),
    .matched    (bitmap_r),
    .hit_vec    (hit_s),
    .any_free   (any_free_s),
    .free_idx   (free_idx_s)
  );

  // Store qualification and the ordered/unordered acceptance decision
  always_comb begin
    valid_s   = '0;
    ord_hit_s = 1'b0;
    for (int i = 0; i < NUM_EXP; i++) begin
      valid_s[i] = (CW'(i) < exp_cnt_r);
      ord_hit_s  = ord_hit_s | (hit_s[i] & (match_cnt_r == CW'(i)));
    end
    store_s    = mem_write & ~(ign_en_r & (data_adr == ign_addr_r));
    good_s     = ordered_r ? ord_hit_s : any_free_s;
    tmo_s      = (cyc_r == TW'(TIMEOUT - 32'sd1));
    next_cnt_s = match_cnt_r + CW'(1'b1);
  end

  // Checker FSM: arming and config latch, matching, timeout, capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cause_r     <= FC_NONE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      ordered_r   <= 1'b0;
      ign_en_r    <= 1'b0;
      ign_addr_r  <= '0;
      exp_cnt_r   <= '0;
      exp_addr_r  <= '0;
      exp_data_r  <= '0;
      bitmap_r    <= '0;
      match_cnt_r <= '0;
      cyc_r       <= '0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
    end else if (start && (state_r != ST_ARMED)) begin
      state_r     <= ST_ARMED;
      cause_r     <= FC_NONE;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      ordered_r   <= ordered;
      ign_en_r    <= ignore_en;
      ign_addr_r  <= ignore_addr;
      exp_cnt_r   <= (exp_count > CW'(NUM_EXP)) ? CW'(NUM_EXP) : exp_count;
      exp_addr_r  <= exp_addr;
      exp_data_r  <= exp_data;
      bitmap_r    <= '0;
      match_cnt_r <= '0;
      cyc_r       <= '0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
    end else begin
      case (state_r)
        ST_ARMED: begin
          cyc_r <= cyc_r + TW'(1'b1);
          if (store_s && good_s) begin
            match_cnt_r <= next_cnt_s;
            if (!ordered_r) begin
              bitmap_r[free_idx_s] <= 1'b1;
            end
            // A completing store beats a timeout on the same edge
            if (next_cnt_s == exp_cnt_r) begin
              state_r <= ST_PASS;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= 1'b1;
            end else if (tmo_s) begin
              state_r <= ST_FAIL;
              cause_r <= FC_TIMEOUT;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              fail_r  <= 1'b1;
            end
          end else if (store_s) begin
            state_r     <= ST_FAIL;
            cause_r     <= (!ordered_r && (|hit_s)) ? FC_DUPLICATE : FC_MISMATCH;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            fail_r      <= 1'b1;
            fail_addr_r <= data_adr;
            fail_data_r <= write_data;
          end else if (exp_cnt_r == '0) begin
            state_r <= ST_PASS;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= 1'b1;
          end else if (tmo_s) begin
            state_r <= ST_FAIL;
            cause_r <= FC_TIMEOUT;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            fail_r  <= 1'b1;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign timeout   = (cause_r == FC_TIMEOUT);
  assign match_cnt = match_cnt_r;
  assign fail_addr = fail_addr_r;
  assign fail_data = fail_data_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed table, corner sequences
// and randomized stimulus against a list-based reference model.
module tb_mem_write_checker;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_EXP = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = 3;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      start = 1'b0;
  logic                      ordered = 1'b0;
  logic                      ignore_en = 1'b0;
  logic [ADDR_W-1:0]         ignore_addr = '0;
  logic [CW-1:0]             exp_count = '0;
  logic [NUM_EXP*ADDR_W-1:0] exp_addr = '0;
  logic [NUM_EXP*DATA_W-1:0] exp_data = '0;
  logic                      mem_write = 1'b0;
  logic [ADDR_W-1:0]         data_adr = '0;
  logic [DATA_W-1:0]         write_data = '0;
  logic                      busy, done, pass, fail, timeout;
  logic [CW-1:0]             match_cnt;
  logic [ADDR_W-1:0]         fail_addr;
  logic [DATA_W-1:0]         fail_data;

  mem_write_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXP(NUM_EXP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ordered(ordered),
    .ignore_en(ignore_en), .ignore_addr(ignore_addr), .exp_count(exp_count),
    .exp_addr(exp_addr), .exp_data(exp_data), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .match_cnt(match_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: remaining expected stores kept as a queue of {addr,data}
  bit          m_busy, m_pass, m_fail, m_tmo, m_ord, m_igen;
  int          m_cnt, m_age;
  logic [31:0] m_fa, m_fd, m_igaddr;
  logic [63:0] m_list[$];

  function automatic void model_reset();
    m_busy = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_tmo = 1'b0;
    m_ord = 1'b0; m_igen = 1'b0; m_igaddr = '0;
    m_cnt = 0; m_age = 0; m_fa = '0; m_fd = '0;
    m_list.delete();
  endfunction

  function automatic void model_finish(bit ok, bit tmo, logic [31:0] a, logic [31:0] d);
    m_busy = 1'b0; m_pass = ok; m_fail = !ok; m_tmo = tmo; m_fa = a; m_fd = d;
  endfunction

  function automatic void model_edge();
    int n;
    int idx;
    bit st;
    logic [63:0] s;
    if (start && !m_busy) begin
      m_ord = ordered; m_igen = ignore_en; m_igaddr = ignore_addr;
      n = (int'(exp_count) > NUM_EXP) ? NUM_EXP : int'(exp_count);
      m_list.delete();
      for (int i = 0; i < n; i++)
        m_list.push_back({exp_addr[i*32 +: 32], exp_data[i*32 +: 32]});
      m_busy = 1'b1; m_pass = 1'b0; m_fail = 1'b0; m_tmo = 1'b0;
      m_cnt = 0; m_age = 0; m_fa = '0; m_fd = '0;
    end else if (m_busy) begin
      m_age++;
      st = mem_write && !(m_igen && (data_adr == m_igaddr));
      s = {data_adr, write_data};
      idx = -1;
      if (st) begin
        if (m_ord) begin
          if (m_list.size() > 0 && m_list[0] == s) idx = 0;
        end else begin
          for (int i = m_list.size() - 1; i >= 0; i--)
            if (m_list[i] == s) idx = i;
        end
        if (idx < 0) model_finish(1'b0, 1'b0, data_adr, write_data);
        else begin
          m_list.delete(idx);
          m_cnt++;
          if (m_list.size() == 0) model_finish(1'b1, 1'b0, '0, '0);
          else if (m_age == TIMEOUT) model_finish(1'b0, 1'b1, '0, '0);
        end
      end else if (m_list.size() == 0) model_finish(1'b1, 1'b0, '0, '0);
      else if (m_age == TIMEOUT) model_finish(1'b0, 1'b1, '0, '0);
    end
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  task automatic chk_all(string tag, bit eb, bit ep, bit ef, bit et, int ec,
                         logic [31:0] efa, logic [31:0] efd);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ep | ef));
    chk({tag, ".pass"}, 32'(pass), 32'(ep));
    chk({tag, ".fail"}, 32'(fail), 32'(ef));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(ec));
    chk({tag, ".fail_addr"}, fail_addr, efa);
    chk({tag, ".fail_data"}, fail_data, efd);
  endtask

  task automatic tick();
    if (reset) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; start = 1'b0; mem_write = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    mem_write = 1'b1; data_adr = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic set_list(bit o, bit ie, logic [31:0] ia, logic [2:0] c,
                          logic [3:0][15:0] ea, logic [3:0][15:0] ed);
    ordered = o; ignore_en = ie; ignore_addr = ia; exp_count = c;
    for (int i = 0; i < NUM_EXP; i++) begin
      exp_addr[i*32 +: 32] = {16'd0, ea[i]};
      exp_data[i*32 +: 32] = {16'd0, ed[i]};
    end
  endtask

  typedef struct packed {
    logic             ord;
    logic             ig_en;
    logic [15:0]      ig_addr;
    logic [2:0]       cnt;
    logic [3:0][15:0] ea;
    logic [3:0][15:0] ed;
    logic [2:0]       nst;
    logic [3:0][15:0] sa;
    logic [3:0][15:0] sd;
    logic             e_busy;
    logic             e_pass;
    logic             e_fail;
    logic [2:0]       e_cnt;
    logic [15:0]      e_fa;
    logic [15:0]      e_fd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] pk;
    vecs[0] = '{ord:1'b1, ig_en:1'b1, ig_addr:16'd96, cnt:3'd1,
                ea:{16'd0,16'd0,16'd0,16'd100}, ed:{16'd0,16'd0,16'd0,16'd7},
                nst:3'd2, sa:{16'd0,16'd0,16'd100,16'd96}, sd:{16'd0,16'd0,16'd7,16'd3},
                e_busy:1'b0, e_pass:1'b1, e_fail:1'b0, e_cnt:3'd1, e_fa:16'd0, e_fd:16'd0};
    vecs[1] = '{ord:1'b1, ig_en:1'b0, ig_addr:16'd0, cnt:3'd2,
                ea:{16'd0,16'd0,16'd84,16'd80}, ed:{16'd0,16'd0,16'd2,16'd1},
                nst:3'd1, sa:{16'd0,16'd0,16'd0,16'd84}, sd:{16'd0,16'd0,16'd0,16'd2},
                e_busy:1'b0, e_pass:1'b0, e_fail:1'b1, e_cnt:3'd0, e_fa:16'd84, e_fd:16'd2};
    vecs[2] = '{ord:1'b0, ig_en:1'b0, ig_addr:16'd0, cnt:3'd3,
                ea:{16'd0,16'd88,16'd84,16'd80}, ed:{16'd0,16'd3,16'd2,16'd1},
                nst:3'd3, sa:{16'd0,16'd84,16'd80,16'd88}, sd:{16'd0,16'd2,16'd1,16'd3},
                e_busy:1'b0, e_pass:1'b1, e_fail:1'b0, e_cnt:3'd3, e_fa:16'd0, e_fd:16'd0};
    vecs[3] = '{ord:1'b0, ig_en:1'b0, ig_addr:16'd0, cnt:3'd3,
                ea:{16'd0,16'd88,16'd84,16'd80}, ed:{16'd0,16'd3,16'd2,16'd1},
                nst:3'd2, sa:{16'd0,16'd0,16'd80,16'd80}, sd:{16'd0,16'd0,16'd1,16'd1},
                e_busy:1'b0, e_pass:1'b0, e_fail:1'b1, e_cnt:3'd1, e_fa:16'd80, e_fd:16'd1};
    vecs[4] = '{ord:1'b0, ig_en:1'b0, ig_addr:16'd0, cnt:3'd2,
                ea:{16'd0,16'd0,16'd84,16'd80}, ed:{16'd0,16'd0,16'd2,16'd1},
                nst:3'd2, sa:{16'd0,16'd0,16'd80,16'd84}, sd:{16'd0,16'd0,16'd5,16'd2},
                e_busy:1'b0, e_pass:1'b0, e_fail:1'b1, e_cnt:3'd1, e_fa:16'd80, e_fd:16'd5};
    vecs[5] = '{ord:1'b1, ig_en:1'b0, ig_addr:16'd0, cnt:3'd2,
                ea:{16'd0,16'd0,16'd84,16'd80}, ed:{16'd0,16'd0,16'd2,16'd1},
                nst:3'd2, sa:{16'd0,16'd0,16'd84,16'd80}, sd:{16'd0,16'd0,16'd2,16'd1},
                e_busy:1'b0, e_pass:1'b1, e_fail:1'b0, e_cnt:3'd2, e_fa:16'd0, e_fd:16'd0};
    vecs[6] = '{ord:1'b1, ig_en:1'b0, ig_addr:16'd0, cnt:3'd7,
                ea:{16'd92,16'd88,16'd84,16'd80}, ed:{16'd4,16'd3,16'd2,16'd1},
                nst:3'd4, sa:{16'd92,16'd88,16'd84,16'd80}, sd:{16'd4,16'd3,16'd2,16'd1},
                e_busy:1'b0, e_pass:1'b1, e_fail:1'b0, e_cnt:3'd4, e_fa:16'd0, e_fd:16'd0};
    vecs[7] = '{ord:1'b1, ig_en:1'b1, ig_addr:16'd84, cnt:3'd2,
                ea:{16'd0,16'd0,16'd84,16'd80}, ed:{16'd0,16'd0,16'd2,16'd1},
                nst:3'd2, sa:{16'd0,16'd0,16'd80,16'd84}, sd:{16'd0,16'd0,16'd1,16'd9},
                e_busy:1'b1, e_pass:1'b0, e_fail:1'b0, e_cnt:3'd1, e_fa:16'd0, e_fd:16'd0};
    vecs[8] = '{ord:1'b1, ig_en:1'b0, ig_addr:16'd0, cnt:3'd0,
                ea:{16'd0,16'd0,16'd0,16'd80}, ed:{16'd0,16'd0,16'd0,16'd1},
                nst:3'd0, sa:{16'd0,16'd0,16'd0,16'd0}, sd:{16'd0,16'd0,16'd0,16'd0},
                e_busy:1'b0, e_pass:1'b1, e_fail:1'b0, e_cnt:3'd0, e_fa:16'd0, e_fd:16'd0};
    vecs[9] = '{ord:1'b0, ig_en:1'b1, ig_addr:16'd96, cnt:3'd0,
                ea:{16'd0,16'd0,16'd0,16'd80}, ed:{16'd0,16'd0,16'd0,16'd1},
                nst:3'd1, sa:{16'd0,16'd0,16'd0,16'd80}, sd:{16'd0,16'd0,16'd0,16'd1},
                e_busy:1'b0, e_pass:1'b0, e_fail:1'b1, e_cnt:3'd0, e_fa:16'd80, e_fd:16'd1};

    // Reset state while reset is still held
    model_reset();
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0);

    // Directed table
    for (int v = 0; v < 10; v++) begin
      apply_reset();
      set_list(vecs[v].ord, vecs[v].ig_en, {16'd0, vecs[v].ig_addr}, vecs[v].cnt,
               vecs[v].ea, vecs[v].ed);
      arm();
      for (int s = 0; s < int'(vecs[v].nst); s++)
        store({16'd0, vecs[v].sa[s]}, {16'd0, vecs[v].sd[s]});
      if (vecs[v].nst == 3'd0) tick();
      chk_all($sformatf("vec%0d", v), vecs[v].e_busy, vecs[v].e_pass, vecs[v].e_fail,
              1'b0, int'(vecs[v].e_cnt), {16'd0, vecs[v].e_fa}, {16'd0, vecs[v].e_fd});
    end

    // Timeout with no stores: fail exactly 16 edges after entering ARMED
    apply_reset();
    set_list(1'b1, 1'b0, 32'd0, 3'd1, {16'd0,16'd0,16'd0,16'd100}, {16'd0,16'd0,16'd0,16'd7});
    arm();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk_all("tmo_pre", 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0);
    tick();
    chk_all("tmo", 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'd0, 32'd0);

    // Completing store on the timeout edge wins; then re-arm
    apply_reset();
    set_list(1'b1, 1'b0, 32'd0, 3'd2, {16'd0,16'd0,16'd84,16'd80}, {16'd0,16'd0,16'd2,16'd1});
    arm();
    store(32'd80, 32'd1);
    for (int i = 0; i < TIMEOUT - 2; i++) tick();
    store(32'd84, 32'd2);
    chk_all("tmo_pass", 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'd0, 32'd0);
    arm();
    chk_all("rearm", 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0);

    // Mismatching store on the timeout edge is a store failure
    apply_reset();
    arm();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    store(32'd88, 32'd5);
    chk_all("tmo_mis", 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'd88, 32'd5);

    // start while ARMED is ignored, later config changes have no effect
    apply_reset();
    arm();
    store(32'd80, 32'd1);
    ordered = 1'b0; exp_addr = '0; exp_count = 3'd4;
    arm();
    chk_all("arm_ign", 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'd0, 32'd0);
    store(32'd84, 32'd2);
    chk_all("cfg_held", 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'd0, 32'd0);

    // Asynchronous reset while ARMED with one match
    apply_reset();
    set_list(1'b1, 1'b0, 32'd0, 3'd2, {16'd0,16'd0,16'd84,16'd80}, {16'd0,16'd0,16'd2,16'd1});
    arm();
    store(32'd80, 32'd1);
    chk_all("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'd0, 32'd0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0);
    #2;
    reset = 1'b1;
    store(32'd80, 32'd1);
    store(32'd84, 32'd2);
    chk_all("idle_ign", 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0, 32'd0);

    // Randomized stimulus against the reference model
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) begin
        ordered     = 1'($urandom_range(0, 1));
        ignore_en   = 1'($urandom_range(0, 1));
        ignore_addr = 32'(80 + 4 * $urandom_range(0, 4));
        exp_count   = 3'($urandom_range(0, 7));
        for (int i = 0; i < NUM_EXP; i++) begin
          exp_addr[i*32 +: 32] = 32'(80 + 4 * $urandom_range(0, 4));
          exp_data[i*32 +: 32] = 32'($urandom_range(0, 3));
        end
      end
      mem_write = ($urandom_range(0, 2) == 0);
      if (m_list.size() > 0 && $urandom_range(0, 2) != 0) begin
        pk = m_list[$urandom_range(0, m_list.size() - 1)];
        data_adr = pk[63:32]; write_data = pk[31:0];
      end else begin
        data_adr   = 32'(80 + 4 * $urandom_range(0, 4));
        write_data = 32'($urandom_range(0, 3));
      end
      tick();
      chk_all("rand", m_busy, m_pass, m_fail, m_tmo, m_cnt, m_fa, m_fd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
